// File: rtl/alu_responder.sv
// ============================================================================
//  Module   : alu_responder
//  Purpose  : Responder for the ALU start/done protocol. Logic ops finish in
//             one cycle. Unsigned multiply uses an iterative shift-add loop.
//             Define ALU_RESPONDER_MUL_EN to build in the multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_responder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);

  localparam logic [2:0] c_op_nop = 3'b000;
  localparam logic [2:0] c_op_add = 3'b001;
  localparam logic [2:0] c_op_and = 3'b010;
  localparam logic [2:0] c_op_xor = 3'b011;
  localparam logic [2:0] c_op_mul = 3'b100;
  localparam logic [2:0] c_op_rst = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_err;
  logic                 w_accept;
  logic [WIDTH:0]       w_sum;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_sum    = {1'b0, A} + {1'b0, B};

`ifdef ALU_RESPONDER_MUL_EN
  localparam int                CW          = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]     c_width_cnt = CW'(WIDTH);
  localparam logic [CW-1:0]     c_last_cnt  = CW'(1);

  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic                 w_mul_start;
  logic                 w_mul_last;

  // Partial product weight follows the number of bits already consumed.
  assign w_addend    = r_b[0] ? ({{WIDTH{1'b0}}, r_a} << (c_width_cnt - r_count))
                              : '0;
  assign w_acc_next  = r_acc + w_addend;
  assign w_mul_start = w_accept && (op == c_op_mul);
  assign w_mul_last  = (r_count == c_last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_count <= '0;
      r_acc   <= '0;
    end else if (w_mul_start) begin
      r_a     <= A;
      r_b     <= B;
      r_count <= c_width_cnt;
      r_acc   <= '0;
    end else if (r_state == S_MUL) begin
      r_b     <= r_b >> 1;
      r_count <= r_count - c_last_cnt;
      r_acc   <= w_acc_next;
    end
  end
`else
  logic w_mul_start;
  logic w_mul_last;
  assign w_mul_start = 1'b0;
  assign w_mul_last  = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mul_start)   w_state_next = S_MUL;
        else if (start)    w_state_next = S_DONE;
      end
      S_MUL: begin
        if (w_mul_last)    w_state_next = S_DONE;
      end
      S_DONE: begin
        w_state_next = start ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!start)        w_state_next = S_IDLE;
      end
      default:             w_state_next = S_IDLE;
    endcase
  end

  // err is only meaningful in the DONE cycle; it is cleared on leaving DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
      case (op)
        c_op_nop: ;
        c_op_add: r_result <= {{(WIDTH-1){1'b0}}, w_sum};
        c_op_and: r_result <= {{WIDTH{1'b0}}, A & B};
        c_op_xor: r_result <= {{WIDTH{1'b0}}, A ^ B};
        c_op_rst: r_result <= '0;
`ifdef ALU_RESPONDER_MUL_EN
        c_op_mul: ;
`endif
        default:  r_err <= 1'b1;
      endcase
`ifdef ALU_RESPONDER_MUL_EN
    end else if ((r_state == S_MUL) && w_mul_last) begin
      r_result <= w_acc_next;
`endif
    end else if (r_state == S_DONE) begin
      r_err <= 1'b0;
    end
  end

  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_responder.sv
// ============================================================================
//  Module   : tb_alu_responder
//  Purpose  : Directed bench for alu_responder with hand-computed expectations.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  A = '0;
  logic [7:0]  B = '0;
  logic [2:0]  op = '0;
  logic        done;
  logic [15:0] result;
  logic        err;

  int n_checks = 0;
  int n_fails  = 0;
  int lat;

  alu_responder #(.WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .A      (A),
    .B      (B),
    .op     (op),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a command and returns the number of cycles from the accepting edge
  // to the done cycle (20 means no done was seen).
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input bit scramble, input bit keep, output int latency);
    A = a; B = b; op = o; start = 1'b1;
    latency = 20;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (scramble && i == 1) begin
        A = 8'h12; B = 8'h34; op = 3'b001;
      end
      if (done) begin
        latency = i;
        break;
      end
    end
    if (!keep) start = 1'b0;
  endtask

  initial begin
    bit seen;

    // Reset values
    tick();
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    tick();

    // Add with carry out
    run_cmd(8'hFF, 8'h01, 3'b001, 0, 0, lat);
    check("add1_lat", lat, 1);
    check("add1_result", result, 16'h0100);
    check("add1_err", err, 0);
    tick();
    check("add1_done_low", done, 0);

    run_cmd(8'h03, 8'h04, 3'b001, 0, 0, lat);
    check("add2_lat", lat, 1);
    check("add2_result", result, 16'h0007);
    tick();

`ifdef ALU_RESPONDER_MUL_EN
    run_cmd(8'hFF, 8'hFF, 3'b100, 1, 0, lat);
    check("mul_lat", lat, 9);
    check("mul_result", result, 16'hFE01);
    check("mul_err", err, 0);
    tick();
    run_cmd(8'h02, 8'h03, 3'b100, 0, 0, lat);
    check("mul2_lat", lat, 9);
    check("mul2_result", result, 16'h0006);
    tick();
`else
    run_cmd(8'h02, 8'h03, 3'b100, 0, 0, lat);
    check("mul_off_lat", lat, 1);
    check("mul_off_err", err, 1);
    check("mul_off_result", result, 16'h0007);
    tick();
    check("mul_off_err_clr", err, 0);
`endif

    // Held start must not retrigger
    run_cmd(8'h0F, 8'hF3, 3'b010, 0, 1, lat);
    check("and_lat", lat, 1);
    check("and_result", result, 16'h0003);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) seen = 1;
    end
    check("held_no_done", seen, 0);
    start = 1'b0;
    tick();
    run_cmd(8'hF0, 8'h3C, 3'b011, 0, 0, lat);
    check("xor_lat", lat, 1);
    check("xor_result", result, 16'h00CC);
    tick();

    // Illegal ops, no_op and rst_op
    run_cmd(8'h11, 8'h22, 3'b101, 0, 0, lat);
    check("ill101_lat", lat, 1);
    check("ill101_err", err, 1);
    check("ill101_result", result, 16'h00CC);
    tick();
    check("ill101_err_clr", err, 0);
    run_cmd(8'h11, 8'h22, 3'b110, 0, 0, lat);
    check("ill110_err", err, 1);
    check("ill110_result", result, 16'h00CC);
    tick();
    run_cmd(8'h11, 8'h22, 3'b000, 0, 0, lat);
    check("nop_lat", lat, 1);
    check("nop_err", err, 0);
    check("nop_result", result, 16'h00CC);
    tick();
    run_cmd(8'h11, 8'h22, 3'b111, 0, 0, lat);
    check("rstop_result", result, 16'h0000);
    check("rstop_err", err, 0);
    tick();

    // Make result nonzero, then reset while idle
    run_cmd(8'h80, 8'h80, 3'b001, 0, 0, lat);
    check("add3_result", result, 16'h0100);
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_idle_result", result, 0);
    check("rst_idle_done", done, 0);
    reset = 1'b0;
    tick();

    // Reset shortly after accepting an op 100 command
    A = 8'h05; B = 8'h07; op = 3'b100; start = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    check("rst_busy_done", done, 0);
    check("rst_busy_result", result, 0);
    check("rst_busy_err", err, 0);
    start = 1'b0;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen = 1;
    end
    check("rst_busy_no_done", seen, 0);
    run_cmd(8'h03, 8'h04, 3'b001, 0, 0, lat);
    check("post_rst_lat", lat, 1);
    check("post_rst_result", result, 16'h0007);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
